dmem_responder: RTL and testbench
=================================

# dmem_responder

Word-addressed data-memory responder for the CPU data port. It accepts one load or store request at a time over a valid/ready request channel and holds storage of DEPTH_WORDS 32-bit words. It returns a response (read data or write acknowledge, plus an error flag) over a valid/ready response channel after a fixed, parameterised latency. It replaces the combinational data memory when the core moves to a handshaked memory interface.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 4.
- LATENCY, 2: cycles from request acceptance to first resp_valid; 1..15.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address.
- req_write  in  1  1 = store, 0 = load.
- req_wdata  in  32  store data.
- req_wstrb  in  4  store byte enables; bit i writes byte i (bits 8i+7:8i).
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP. Only one request is outstanding at a time.
- IDLE: req_ready=1, resp_valid=0. An acceptance is req_valid && req_ready at a rising edge.
  - On acceptance, go to RESP if LATENCY=1.
  - Otherwise load the wait counter with LATENCY-1 and go to WAIT.
- WAIT: req_ready=0, resp_valid=0. The counter decrements once per cycle. On the edge where the counter is 1, go to RESP.
- RESP: req_ready=0, resp_valid=1, and resp_rdata/resp_err are held stable. On resp_valid && resp_ready, go to IDLE.
- Error check, evaluated at acceptance:
  - err = (req_addr[1:0] != 0) || (req_addr[31:2] >= DEPTH_WORDS).
  - An errored request performs no memory access. Its response carries rdata=0, err=1.
- Load, no error: the word at req_addr[31:2] is captured into the response register at the acceptance edge. resp_rdata shows that value; err=0.
- Store, no error: bytes selected by req_wstrb are written at the acceptance edge. Response carries rdata=0, err=0.
  - wstrb=0 is legal; nothing is written and an ack is still returned.
- The response register is loaded only at acceptance. A load after a store to the same word returns the stored value.
- Request inputs are ignored whenever req_ready=0.

## Timing
- Reset (rst=0 at an edge):
  - State becomes IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; counter cleared.
  - Memory contents are not cleared.
  - Reset mid-transaction drops the transaction with no response. A store accepted before reset stays committed.
  - Reset overrides any simultaneous acceptance; no write occurs on that edge.
- Latency: for acceptance at edge k, resp_valid is first high in the cycle after edge k+LATENCY-1.
  - LATENCY=1 gives resp_valid one cycle after acceptance.
- Back-pressure: resp_valid stays high with stable data until resp_ready=1. There is no timeout.
- Throughput: after response handshake at edge m, req_ready is high in the cycle after m. Next acceptance is earliest at edge m+1.
  - Maximum rate is one transaction per LATENCY+1 cycles.
- All outputs are driven from registers; no combinational path from inputs to outputs.

## Test plan
- Reset then idle: hold rst=0 for 2 cycles, then release. Required: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Store then load (LATENCY=2, resp_ready=1):
  - Store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF. Required: ack with err=0 two cycles after acceptance.
  - Load 0x10. Required: resp_rdata=0xDEADBEEF, err=0, resp_valid high for exactly 1 cycle.
- Byte strobes: store 0x11223344 with wstrb 0xF to 0x20, then store 0xAABBCCDD with wstrb 0x5 to 0x20. Required: load 0x20 returns 0x11BB33DD.
- Errors:
  - Load 0x22 (misaligned). Required: err=1, rdata=0.
  - Store 0x1000 with DEPTH_WORDS=1024 (out of range). Required: err=1, and a subsequent load of 0x0 is unchanged.
- Back-pressure: load with resp_ready=0 for 5 cycles. Required: resp_valid and resp_rdata stable for all 5 cycles, req_ready=0 throughout. Raise resp_ready; req_ready=1 the next cycle.
- Reset mid-transaction: drive rst=0 in WAIT. Required: resp_valid never asserts for the dropped request; req_ready=1 after reset. A store accepted before reset reads back its value.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_responder
//  Brief   : Word-addressed data memory behind valid/ready request/response
//            channels, one outstanding request, fixed response latency.
//  Rev     : 1.0
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         c_AW     = $clog2(DEPTH_WORDS);
    // Bit 0 of the state is req_ready and bit 1 is resp_valid, so both
    // handshake outputs come straight from the state register.
    localparam logic [1:0] c_WAIT   = 2'b00;
    localparam logic [1:0] c_IDLE   = 2'b01;
    localparam logic [1:0] c_RESP   = 2'b10;
    localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

    logic [1:0]      r_state;
    logic [3:0]      r_cnt;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_err;
    logic            w_wr_en;
    logic [c_AW-1:0] w_idx;

    assign w_accept = req_valid && r_state[0];
    assign w_idx    = req_addr[c_AW+1:2];
    assign w_err    = (req_addr[1:0] != 2'b00) || (req_addr[31:c_AW+2] != '0);
    assign w_wr_en  = rst && w_accept && req_write && !w_err;

    // Storage is never reset; a store committed before reset must survive it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_err   <= w_err;
                        r_rdata <= (!w_err && !req_write) ? r_mem[w_idx] : 32'd0;
                        if (LATENCY == 1) begin
                            r_state <= c_RESP;
                        end else begin
                            r_cnt   <= c_LAT_M1;
                            r_state <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    if (resp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign req_ready  = r_state[0];
    assign resp_valid = r_state[1];
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// Testbench for dmem_responder: table of transactions checked through a
// scoreboard queue, plus back-pressure and reset corner sequences.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[14];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [31:0] er, input logic ee);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // hold = number of response cycles with resp_ready low before accepting
    task automatic run_txn(input vec_t v, input int hold);
        int   n;
        bit   seen;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready before request", 32'(req_ready), 32'd1);
        if (!req_ready) return;
        resp_ready = (hold == 0);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_wstrb  = v.strb;
        sbq.push_back('{v.exp_rdata, v.exp_err});
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("resp_valid arrival", 32'(seen), 32'd1);
        if (!seen) begin
            void'(sbq.pop_front());
            resp_ready = 1'b1;
            return;
        end
        chk("latency", 32'(n), 32'(LAT));
        e = sbq.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("req_ready during resp", 32'(req_ready), 32'd0);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk("held resp_valid", 32'(resp_valid), 32'd1);
            chk("held resp_rdata", resp_rdata, e.rdata);
            chk("held req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("resp_valid after handshake", 32'(resp_valid), 32'd0);
        chk("req_ready after handshake", 32'(req_ready), 32'd1);
    endtask

    // Accept a request, then reset while it is in WAIT; it must never respond.
    task automatic reset_mid(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("in WAIT req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("resp_valid during reset", 32'(resp_valid), 32'd0);
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("dropped resp_valid", 32'(resp_valid), 32'd0);
            chk("req_ready after reset", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0);
        vecs[1]  = mk(1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
        vecs[2]  = mk(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,         1'b0);
        vecs[3]  = mk(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0);
        vecs[4]  = mk(1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0);
        vecs[5]  = mk(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0);
        vecs[6]  = mk(1'b0, 32'h0000_0022, 32'h0,         4'h0, 32'h0,         1'b1);
        vecs[7]  = mk(1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0,         1'b1);
        vecs[8]  = mk(1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);
        vecs[9]  = mk(1'b1, 32'h0000_0024, 32'h0102_0304, 4'hF, 32'h0,         1'b0);
        vecs[10] = mk(1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0);
        vecs[11] = mk(1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'h0102_0304, 1'b0);
        vecs[12] = mk(1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 4'hF, 32'h0,         1'b0);
        vecs[13] = mk(1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h5A5A_5A5A, 1'b0);

        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i], 0);
        end

        run_txn(mk(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0), 5);
        run_txn(mk(1'b1, 32'h0000_1003, 32'h1, 4'hF, 32'h0, 1'b1), 0);

        run_txn(mk(1'b1, 32'h0000_0030, 32'h7777_8888, 4'hF, 32'h0, 1'b0), 0);
        reset_mid(1'b0, 32'h0000_0030, 32'h0);
        run_txn(mk(1'b0, 32'h0000_0030, 32'h0, 4'h0, 32'h7777_8888, 1'b0), 0);

        reset_mid(1'b1, 32'h0000_0034, 32'h1357_9BDF);
        run_txn(mk(1'b0, 32'h0000_0034, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0), 0);

        // A store presented on the same edge as reset must not be written.
        run_txn(mk(1'b1, 32'h0000_0038, 32'hAAAA_0000, 4'hF, 32'h0, 1'b0), 0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0038;
        req_wdata = 32'h5555_5555;
        req_wstrb = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("overlap resp_valid", 32'(resp_valid), 32'd0);
        end
        run_txn(mk(1'b0, 32'h0000_0038, 32'h0, 4'h0, 32'hAAAA_0000, 1'b0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
